fetch_unit: RTL and testbench

Instruction fetch front end of the vector CPU. Holds the program counter, issues one instruction-memory read at a time, buffers the returned word and presents it with its PC to decode over a valid/ready handshake. Branch/jump redirects from execute override sequential fetch and discard any in-flight or buffered instruction.

---
 rtl/vec_cpu_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 32 +++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_cpu_pkg.sv
// Shared types and constants for the vector CPU front end.
package vec_cpu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch sequencer states: request outstanding, draining a stale read, holding for decode
  typedef enum logic [1:0] {
    StReq,
    StDrop,
    StHold
  } fetch_state_t;

  // Instructions are word aligned; low address bits are ignored
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry holding register for a fetched instruction and its PC.
// Load wins over flush; flush only clears the valid flag so data stays stable.
module fetch_buf
  import vec_cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Capture a returned word or drop the held one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, single-entry buffer,
// valid/ready hand-off to decode, redirect from execute overrides everything.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_unit
  import vec_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              started_q;
  logic [ADDR_W-1:0] target;
  logic              buf_load;
  logic              buf_flush;
  logic              accept;

  assign target    = align_pc(redirect_pc);
  // Request is suppressed until the first clock edge after reset release
  assign imem_req  = started_q && (state_q != StHold);
  assign imem_addr = req_addr_q;

  // Buffer control and decode handshake qualification
  always_comb begin
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    accept    = 1'b0;
    if (state_q == StReq && started_q && imem_valid && !redirect) begin
      buf_load = 1'b1;
    end
    if (state_q == StHold) begin
      buf_flush = if_ready || redirect;
      accept    = if_ready && !redirect;
    end
  end

  // Fetch sequencer: pc, outstanding address and state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      started_q  <= 1'b0;
    end else begin
      started_q <= 1'b1;
      case (state_q)
        StReq: begin
          if (started_q) begin
            if (redirect && imem_valid) begin
              // Response is stale; reissue immediately at the target
              pc_q       <= target;
              req_addr_q <= target;
            end else if (redirect) begin
              // Read still in flight; wait for it to drain before reissuing
              pc_q    <= target;
              state_q <= StDrop;
            end else if (imem_valid) begin
              pc_q    <= req_addr_q + PC_STEP;
              state_q <= StHold;
            end
          end
        end
        StDrop: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (imem_valid) begin
            req_addr_q <= redirect ? target : pc_q;
            state_q    <= StReq;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_q       <= target;
            req_addr_q <= target;
            state_q    <= StReq;
          end else if (if_ready) begin
            req_addr_q <= pc_q;
            state_q    <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .flush      (buf_flush),
    .load_instr (imem_rdata),
    .load_pc    (req_addr_q),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc)
  );

`ifdef FETCH_PERF_EN
  // Completed decode handshakes and backpressure cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (state_q == StHold && !if_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed memory responses, scoreboard of
// instructions expected at the decode handshake.
module tb_fetch_unit;
  import vec_cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must be the oldest expected one
  always @(posedge clk) begin
    if (rst_n && if_valid && if_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        check("unexpected_handshake_pc", if_pc, 32'hFFFF_FFFF);
      end else begin
        sb_e = sb_q.pop_front();
        check("hs_instr", if_instr, sb_e.instr);
        check("hs_pc", if_pc, sb_e.pc);
      end
    end
  end

  // Wait for a request, let it stand one cycle, then answer with data
  task automatic fetch(input logic [31:0] data, input logic [31:0] addr, input bit keep);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    @(negedge clk);
    check("imem_addr", imem_addr, addr);
    imem_valid = 1'b1;
    imem_rdata = data;
    if (keep) sb_q.push_back({data, addr});
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
    check("valid_latency", 32'(if_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Sequential fetch, decode always ready
    if_ready = 1'b1;
    fetch(32'hA0, 32'h0, 1'b1);
    fetch(32'hA1, 32'h4, 1'b1);
    @(negedge clk);
    check("after_hs_valid", 32'(if_valid), 32'd0);
    check("after_hs_req", 32'(imem_req), 32'd1);

    // Backpressure for five cycles
    if_ready = 1'b0;
    fetch(32'hB0, 32'h8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(if_valid), 32'd1);
      check("bp_instr", if_instr, 32'hB0);
      check("bp_pc", if_pc, 32'h8);
      check("bp_req", 32'(imem_req), 32'd0);
    end
`ifdef FETCH_PERF_EN
    check("perf_stall", perf_stall_cnt, 32'd5);
`endif
    if_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(if_valid), 32'd0);
    check("bp_release_req", 32'(imem_req), 32'd1);
    check("bp_release_addr", imem_addr, 32'hC);
`ifdef FETCH_PERF_EN
    check("perf_fetch_3", perf_fetch_cnt, 32'd3);
`endif

    // Redirect while the read at 0xC is outstanding
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr_old", imem_addr, 32'hC);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
    check("drop_no_valid", 32'(if_valid), 32'd0);
    check("drop_new_addr", imem_addr, 32'h100);
    fetch(32'hC0, 32'h100, 1'b1);

    // Redirect coinciding with if_ready in HOLD drops the instruction
    @(negedge clk);
    if_ready = 1'b0;
    fetch(32'hD0, 32'h104, 1'b0);
    if_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    check("hold_redir_valid", 32'(if_valid), 32'd0);
    check("hold_redir_req", 32'(imem_req), 32'd1);
    check("hold_redir_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_EN
    check("perf_fetch_4", perf_fetch_cnt, 32'd4);
`endif
    fetch(32'hE0, 32'h100, 1'b1);

    // Redirect together with a response, target at the top of the address space
    repeat (2) @(negedge clk);
    imem_valid  = 1'b1;
    imem_rdata  = 32'hBAD;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
    redirect   = 1'b0;
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_no_valid", 32'(if_valid), 32'd0);
    fetch(32'hF0, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    check("wrap_next_addr", imem_addr, 32'h0);
    fetch(32'hF1, 32'h0, 1'b1);
    @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_fetch_final", perf_fetch_cnt, 32'd7);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
